// File: rtl/rf_wb_port.sv
// rf_wb_port: 32x32 register file with write-through bypass, commit trace and retired counter
module rf_wb_port #(
   parameter int BYPASS = 1,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      wR,
   input  logic [31:0]     wD,
   input  logic [4:0]      rR1,
   input  logic [4:0]      rR2,
   output logic [31:0]     rD1,
   output logic [31:0]     rD2,
   input  logic            wb_have_inst,
   input  logic [PC_W-1:0] wb_pc,
   output logic            debug_wb_have_inst,
   output logic [PC_W-1:0] debug_wb_pc,
   output logic            debug_wb_ena,
   output logic [4:0]      debug_wb_reg,
   output logic [31:0]     debug_wb_value,
   output logic [31:0]     retired_cnt
);
   logic [31:0] x [1:31];
   logic        wr_ok;
   assign wr_ok = we && (wR != 5'd0);
   // architectural state: x0 is hardwired zero so only x1..x31 exist
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) x[i] <= '0;
      end else if (wr_ok) begin
         x[wR] <= wD;
      end
   end
   // asynchronous reads, optionally forwarding the value being written this cycle
   always_comb begin
      rD1 = (rR1 == 5'd0) ? 32'd0 : (BYPASS != 0 && we && wR == rR1) ? wD : x[rR1];
      rD2 = (rR2 == 5'd0) ? 32'd0 : (BYPASS != 0 && we && wR == rR2) ? wD : x[rR2];
   end
   // commit trace and retired counter lag write-back by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         debug_wb_have_inst <= 1'b0;
         debug_wb_pc        <= '0;
         debug_wb_ena       <= 1'b0;
         debug_wb_reg       <= '0;
         debug_wb_value     <= '0;
         retired_cnt        <= '0;
      end else begin
         debug_wb_have_inst <= wb_have_inst;
         debug_wb_pc        <= wb_pc;
         debug_wb_ena       <= wb_have_inst && wr_ok;
         debug_wb_reg       <= wR;
         debug_wb_value     <= wD;
         retired_cnt        <= retired_cnt + {31'd0, wb_have_inst};
      end
   end
endmodule
